// File: rtl/nibble_serial_add_ctrl.sv
// Serial wide adder/subtractor: reuses one 4-bit ripple-carry slice over
// WIDTH/4 cycles, LS nibble first, between valid/ready source and sink.

module add4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [4:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < 4; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[4];
  end
endmodule

module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int NSLICE = WIDTH / 4;
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
    $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4 and >= 4");
  end

  logic [1:0]       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry;
  logic [IW-1:0]    idx;
  logic [3:0]       sl_a;
  logic [3:0]       sl_b;
  logic [3:0]       sl_s;
  logic             sl_c;
  logic             last;

  assign sl_a      = a_q[4*idx +: 4];
  assign sl_b      = b_q[4*idx +: 4];
  assign last      = (idx == IW'(NSLICE - 1));
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  add4_slice u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry),
    .s    (sl_s),
    .cout (sl_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Subtraction is A + ~B + 1: invert B once here, seed carry with 1.
            a_q      <= op_a;
            b_q      <= sub ? ~op_b : op_b;
            carry    <= sub | cin;
            idx      <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          sum[4*idx +: 4] <= sl_s;
          carry           <= sl_c;
          idx             <= idx + 1'b1;
          if (last) begin
            cout     <= sl_c;
            overflow <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sl_s[3] != a_q[WIDTH-1]);
            state    <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Bench for nibble_serial_add_ctrl: directed WIDTH=16 cases plus randomized
// lanes at WIDTH=4/16/32 checked against an arithmetic reference model.

module tb_nibble_serial_add_ctrl;
  localparam int NOPS = 1000;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [2:0] lane_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Result packed as {overflow, cout, sum[w-1:0]}.
  function automatic longint unsigned model(input int w, input longint unsigned a,
                                            input longint unsigned b, input bit s, input bit c);
    longint unsigned m, full;
    longint sa, sbv, r, hi, lo;
    bit ov;
    m    = (64'd1 << w) - 1;
    a    = a & m;
    b    = b & m;
    full = s ? (a + ((~b) & m) + 1) : (a + b + longint'(c));
    sa   = longint'(a);
    sbv  = longint'(b);
    if (a >= (64'd1 << (w - 1))) sa  = sa  - longint'(64'd1 << w);
    if (b >= (64'd1 << (w - 1))) sbv = sbv - longint'(64'd1 << w);
    r  = s ? (sa - sbv) : (sa + sbv + longint'(c));
    hi = longint'(m >> 1);
    lo = -hi - 1;
    ov = (r > hi) || (r < lo);
    return (longint'(ov) << (w + 1)) | (((full >> w) & 1) << w) | (full & m);
  endfunction

  // ---------------- directed instance (WIDTH=16) ----------------
  logic        d_rst_n, d_iv, d_ir, d_ov, d_or, d_sub, d_cin, d_co, d_of;
  logic [15:0] d_a, d_b, d_s;

  nibble_serial_add_ctrl #(.WIDTH(16)) u_dut_dir (
    .clk(clk), .rst_n(d_rst_n), .in_valid(d_iv), .in_ready(d_ir),
    .op_a(d_a), .op_b(d_b), .sub(d_sub), .cin(d_cin),
    .out_valid(d_ov), .out_ready(d_or), .sum(d_s), .cout(d_co), .overflow(d_of)
  );

  // Returns at the falling edge right after the accept edge.
  task automatic d_issue(input logic [15:0] a, input logic [15:0] b, input logic s, input logic c);
    int n;
    @(negedge clk);
    d_iv = 1'b1; d_a = a; d_b = b; d_sub = s; d_cin = c;
    n = 0;
    while (!d_ir && n < 50) begin @(negedge clk); n++; end
    chk("accept_ready", d_ir, 1);
    @(negedge clk);
    d_iv = 1'b0; d_a = 16'($urandom); d_b = 16'($urandom);
    d_sub = 1'($urandom); d_cin = 1'($urandom);
  endtask

  task automatic d_wait(output int lat, output int nrdy);
    lat = 0; nrdy = 0;
    while (!d_ov && lat < 50) begin
      if (!d_ir) nrdy++;
      @(negedge clk);
      lat++;
    end
    if (!d_ir) nrdy++;
    chk("result_arrived", d_ov, 1);
  endtask

  task automatic d_result(input string nm, input logic [15:0] es, input logic ec, input logic eo);
    chk({nm, "_sum"}, d_s, es);
    chk({nm, "_cout"}, d_co, ec);
    chk({nm, "_ovf"}, d_of, eo);
  endtask

  // ---------------- random lanes ----------------
  for (genvar g = 0; g < 3; g++) begin : lane
    localparam int W = (g == 0) ? 4 : (g == 1) ? 16 : 32;
    logic         iv, ir, ov, orr, sb, ci, co, of;
    logic [W-1:0] a, b, s;
    longint unsigned q[$];
    int   issued, got, idle;
    logic pv, pr;

    nibble_serial_add_ctrl #(.WIDTH(W)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir),
      .op_a(a), .op_b(b), .sub(sb), .cin(ci),
      .out_valid(ov), .out_ready(orr), .sum(s), .cout(co), .overflow(of)
    );

    initial begin
      iv = 1'b0; orr = 1'b0; a = '0; b = '0; sb = 1'b0; ci = 1'b0;
      issued = 0; got = 0; idle = 0; pv = 1'b0; pr = 1'b0;
      wait (rst_n === 1'b1);
      while (got < NOPS) begin
        @(negedge clk);
        if (pv && pr) begin
          q.push_back(model(W, 64'(a), 64'(b), sb, ci));
          issued++;
        end
        chk($sformatf("w%0d_ready_xor_valid", W), 64'(ir & ov), 0);
        if (ov) begin
          idle = 0;
          if (q.size() == 0) begin
            total++; bad++;
            $display("FAIL w%0d_spurious_result: got out_valid=1 expected 0", W);
            break;
          end
          chk($sformatf("w%0d_result", W), 64'({of, co, s}), q[0]);
          orr = ($urandom_range(3) != 0);
          if (orr) begin void'(q.pop_front()); got++; end
        end else begin
          orr = 1'($urandom);
          if (q.size() > 0) idle++; else idle = 0;
          if (idle > 100) begin
            total++; bad++;
            $display("FAIL w%0d_timeout: got no result after %0d cycles expected one", W, idle);
            break;
          end
        end
        if (!pv || pr) begin
          if (issued < NOPS && $urandom_range(2) != 0) iv = 1'b1;
          else iv = 1'b0;
          a = W'($urandom); b = W'($urandom); sb = 1'($urandom); ci = 1'($urandom);
        end
        pv = iv; pr = ir;
      end
      iv = 1'b0;
      chk($sformatf("w%0d_results_count", W), 64'(got), 64'(NOPS));
      chk($sformatf("w%0d_queue_empty", W), 64'(q.size()), 0);
      lane_done[g] = 1'b1;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int lat, nrdy;
    total = 0; bad = 0; lane_done = '0;
    rst_n = 1'b0; d_rst_n = 1'b0;
    d_iv = 1'b0; d_or = 1'b0; d_a = '0; d_b = '0; d_sub = 1'b0; d_cin = 1'b0;

    // model pinned against hand-computed values
    chk("model_ripple", model(16, 64'hFFFF, 64'h1, 1'b0, 1'b0), 64'h10000);
    chk("model_ovf_add", model(16, 64'h7FFF, 64'h1, 1'b0, 1'b0), 64'h28000);
    chk("model_borrow", model(16, 64'h0, 64'h1, 1'b1, 1'b1), 64'h0FFFF);
    chk("model_ovf_sub", model(16, 64'h8000, 64'h1, 1'b1, 1'b1), 64'h37FFF);

    #1;
    chk("reset_sum", d_s, 0);
    chk("reset_valid", d_ov, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1; d_rst_n = 1'b1;
    #1;
    chk("reset_ready", d_ir, 1);

    // carry ripple, latency, ready-low duration
    d_or = 1'b1;
    d_issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    d_wait(lat, nrdy);
    chk("ripple_latency", 64'(lat), 4);
    chk("ripple_ready_low", 64'(nrdy), 5);
    d_result("ripple", 16'h0000, 1'b1, 1'b0);
    @(negedge clk);
    chk("ripple_valid_1cyc", d_ov, 0);
    chk("ripple_ready_back", d_ir, 1);

    d_issue(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    d_wait(lat, nrdy);
    d_result("ovf_add", 16'h8000, 1'b0, 1'b1);

    d_issue(16'h0000, 16'h0001, 1'b1, 1'b1);
    d_wait(lat, nrdy);
    d_result("sub_borrow", 16'hFFFF, 1'b0, 1'b0);

    d_issue(16'h8000, 16'h0001, 1'b1, 1'b1);
    d_wait(lat, nrdy);
    d_result("sub_ovf", 16'h7FFF, 1'b1, 1'b1);

    // backpressure with noisy source
    @(negedge clk);
    d_or = 1'b0;
    d_issue(16'h1234, 16'h4321, 1'b0, 1'b1);
    d_wait(lat, nrdy);
    for (int i = 0; i < 10; i++) begin
      d_result("bp_hold", 16'h5556, 1'b0, 1'b0);
      chk("bp_valid", d_ov, 1);
      chk("bp_ready", d_ir, 0);
      d_iv = 1'b1; d_a = 16'($urandom); d_b = 16'($urandom);
      d_sub = 1'($urandom); d_cin = 1'($urandom);
      @(negedge clk);
    end
    d_iv = 1'b0; d_or = 1'b1;
    @(negedge clk);
    chk("bp_done_valid", d_ov, 0);
    chk("bp_done_ready", d_ir, 1);
    chk("bp_sum_kept", d_s, 16'h5556);

    // reset mid-operation
    d_issue(16'hAAAA, 16'h5555, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    d_rst_n = 1'b0;
    #1;
    d_result("midrst", 16'h0000, 1'b0, 1'b0);
    chk("midrst_valid", d_ov, 0);
    @(negedge clk);
    d_rst_n = 1'b1;
    #1;
    chk("midrst_ready", d_ir, 1);
    chk("midrst_valid_after", d_ov, 0);
    d_issue(16'h0003, 16'h0004, 1'b0, 1'b0);
    d_wait(lat, nrdy);
    d_result("after_rst", 16'h0007, 1'b0, 1'b0);

    fork
      wait (lane_done == 3'b111);
      repeat (80000) @(posedge clk);
    join_any
    disable fork;
    chk("lanes_finished", 64'(lane_done), 64'h7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
